multi_addr_comparator: RTL

MULTI_ADDR_COMPARATOR -- requirements
Module: multi_addr_comparator

---
 rtl/multi_addr_comparator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multi_addr_comparator.sv
// Streaming address matcher: slides a byte window over 32-bit beats and flags
// any enabled table address found inside the current frame.
module multi_addr_comparator #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_BYTES  = 6,
  localparam int AW = 8 * ADDR_BYTES,
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic [31:0]   data_in,
  input  logic          data_valid,
  input  logic          sof,
  input  logic          eof,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_idx,
  input  logic [AW-1:0] prog_addr,
  input  logic          prog_en,
  output logic [31:0]   data_out,
  output logic          data_out_valid,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic [1:0]    hit_offset,
  output logic          frame_match,
  output logic [7:0]    hit_count,
  output logic          frame_done
);
  localparam int L = ADDR_BYTES + 3;
  localparam logic [3:0]  L_C  = 4'(L);
  localparam logic [IW:0] NE_C = (IW + 1)'(NUM_ENTRIES);

  logic [7:0]    hist_q    [L];
  logic [7:0]    hist_base [L];
  logic [7:0]    hist_d    [L];
  logic [3:0]    bif_q, bif_d;
  logic [AW-1:0] tab_addr_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tab_en_q;

  logic [AW-1:0] cand [4];
  logic [3:0]    cand_ok;
  logic          match_found;
  logic [IW-1:0] match_idx;
  logic [1:0]    match_off;
  logic          frame_match_d;
  logic [7:0]    hit_count_d;

  logic [31:0]   data_out_q;
  logic          data_out_valid_q, hit_q, frame_match_q, frame_done_q;
  logic [IW-1:0] hit_idx_q;
  logic [1:0]    hit_offset_q;
  logic [7:0]    hit_count_q;

  function automatic logic [3:0] bif_next(input logic [3:0] cur, input logic first);
    if (first) return 4'd4;
    if (cur >= L_C - 4'd4) return L_C;
    return cur + 4'd4;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cur, input logic inc);
    if (!inc || cur == 8'hFF) return cur;
    return cur + 8'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < L; i++) hist_base[i] = sof ? 8'h00 : hist_q[i];
  end

  always_comb begin
    for (int i = 0; i < L - 4; i++) hist_d[i] = hist_base[i + 4];
    for (int j = 0; j < 4; j++) hist_d[L - 4 + j] = data_in[31 - 8*j -: 8];
  end

  assign bif_d = bif_next(bif_q, sof);

  // A candidate is only legal once every byte it covers belongs to this frame.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cand[k] = '0;
      for (int b = 0; b < ADDR_BYTES; b++) cand[k][AW - 1 - 8*b -: 8] = hist_d[k + b];
      cand_ok[k] = (bif_d >= L_C - 4'(k));
    end
  end

  // Reverse scan so the lowest entry, then lowest k, is the last writer.
  // hit_offset reports the byte lane (within its beat) where the match starts.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    match_off   = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      for (int k = 3; k >= 0; k--) begin
        if (tab_en_q[e] && cand_ok[k] && (tab_addr_q[e] == cand[k])) begin
          match_found = 1'b1;
          match_idx   = IW'(e);
          match_off   = 2'(k + 1 - ADDR_BYTES);
        end
      end
    end
  end

  assign frame_match_d = (sof ? 1'b0 : frame_match_q) | match_found;
  assign hit_count_d   = sat_inc(sof ? 8'd0 : hit_count_q, match_found);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < L; i++) hist_q[i] <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) tab_addr_q[e] <= '0;
      tab_en_q         <= '0;
      bif_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      hit_q            <= 1'b0;
      hit_idx_q        <= '0;
      hit_offset_q     <= '0;
      frame_match_q    <= 1'b0;
      hit_count_q      <= '0;
      frame_done_q     <= 1'b0;
    end else begin
      if (prog_we && ({1'b0, prog_idx} < NE_C)) begin
        tab_addr_q[prog_idx] <= prog_addr;
        tab_en_q[prog_idx]   <= prog_en;
      end
      if (clear) begin
        for (int i = 0; i < L; i++) hist_q[i] <= '0;
        bif_q            <= '0;
        data_out_q       <= '0;
        data_out_valid_q <= 1'b0;
        hit_q            <= 1'b0;
        hit_idx_q        <= '0;
        hit_offset_q     <= '0;
        frame_match_q    <= 1'b0;
        hit_count_q      <= '0;
        frame_done_q     <= 1'b0;
      end else begin
        data_out_valid_q <= data_valid;
        hit_q            <= data_valid & match_found;
        frame_done_q     <= data_valid & eof;
        if (data_valid) begin
          data_out_q    <= data_in;
          hist_q        <= hist_d;
          bif_q         <= eof ? 4'd0 : bif_d;
          frame_match_q <= frame_match_d;
          hit_count_q   <= hit_count_d;
          if (match_found) begin
            hit_idx_q    <= match_idx;
            hit_offset_q <= match_off;
          end
        end
      end
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign hit            = hit_q;
  assign hit_idx        = hit_idx_q;
  assign hit_offset     = hit_offset_q;
  assign frame_match    = frame_match_q;
  assign hit_count      = hit_count_q;
  assign frame_done     = frame_done_q;

endmodule
